skid_buffer: RTL and testbench

- Single-stage ready/valid pipeline register with a one-entry skid slot.
- Sits directly downstream of a plain enabled register. It converts that register's enable-style output into a streaming interface that tolerates backpressure at full throughput.
- in_ready is fully registered, which breaks the combinational ready path between producer and consumer.
- Used wherever an enabled register has to drive a consumer that can stall.

---
 rtl/skid_buffer_pkg.sv | 26 ++
 rtl/skid_buffer.sv | 118 +++++++++++
 tb/tb_skid_buffer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/skid_buffer_pkg.sv
// -----------------------------------------------------------------------------
// skid_buffer_pkg
// Shared types and constants for the skid_buffer ready/valid stage.
//   state_t     : occupancy state of the buffer (EMPTY / HALF / FULL)
//   MAX_COUNT   : maximum number of words the buffer can hold
//   state_count : maps a state onto its occupancy value
// -----------------------------------------------------------------------------
package skid_buffer_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam int MAX_COUNT = 2;

   // The state encoding is chosen so that the encoding itself is the occupancy.
   function automatic logic [1:0] state_count(input state_t s);
      logic [1:0] c;
      c = s;
      if (c > 2'(MAX_COUNT)) c = 2'(MAX_COUNT);
      return c;
   endfunction

endpackage

// File: rtl/skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
// Single-stage ready/valid register with a one-entry skid slot. Accepts one
// word per cycle under continuous flow and absorbs one extra word when the
// consumer stalls, so in_ready can come straight from a flop.
//
// Ports:
//   clk        in   clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream word present on in_data
//   in_ready   out  buffer accepts a word this cycle (registered)
//   in_data    in   upstream payload, WIDTH bits
//   out_valid  out  out_data holds a valid word (registered)
//   out_ready  in   downstream takes out_data this cycle
//   out_data   out  payload to downstream, WIDTH bits (registered)
//   count      out  occupancy 0..2 (debug)
// -----------------------------------------------------------------------------
module skid_buffer
   import skid_buffer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   state_t           state_q;
   state_t           state_d;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;

   logic             in_xfer;
   logic             out_xfer;
   logic             load_main_in;
   logic             load_main_skid;
   logic             load_skid;

   assign in_xfer  = in_valid && in_ready_q;
   assign out_xfer = out_valid_q && out_ready;

   // Next-state and register-enable decode.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         EMPTY: begin
            // Nothing to present, so out_ready has no effect here.
            if (in_xfer) begin
               load_main_in = 1'b1;
               state_d      = HALF;
            end
         end
         HALF: begin
            if (in_xfer && out_xfer) begin
               // Pass-through: the new word replaces the one just consumed.
               load_main_in = 1'b1;
            end else if (in_xfer) begin
               // Consumer stalled; park the word in the skid slot so that
               // out_data stays untouched.
               load_skid = 1'b1;
               state_d   = FULL;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low, so only a drain can happen.
            if (out_xfer) begin
               load_main_skid = 1'b1;
               state_d        = HALF;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // ---- register stage: control and data flops ----
   // in_ready and out_valid are registered copies of the next state so that
   // neither handshake output has a combinational path from the inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_q      <= '0;
         skid_q      <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != FULL);
         out_valid_q <= (state_d != EMPTY);
         if (load_main_in) begin
            main_q <= in_data;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign count     = state_count(state_q);

endmodule

// File: tb/tb_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_skid_buffer
// Self-checking bench for skid_buffer: reset checks, a directed vector table,
// hand-written corner sequences and a randomized run against a queue model.
// -----------------------------------------------------------------------------
module tb_skid_buffer;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       count;

   int checks   = 0;
   int failures = 0;

   // Reference model: the buffer contents as a plain FIFO of at most 2 words.
   logic [WIDTH-1:0] model_q[$];

   skid_buffer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance past the edge and update the model.
   task automatic cycle(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
      bit acc_in, acc_out;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      acc_in    = iv && (model_q.size() < 2);
      acc_out   = (model_q.size() > 0) && ordy;
      @(posedge clk);
      #1;
      if (acc_out) void'(model_q.pop_front());
      if (acc_in) model_q.push_back(d);
   endtask

   task automatic check_model(input string tag);
      check({tag, ".out_valid"}, out_valid, model_q.size() > 0);
      check({tag, ".in_ready"}, in_ready, model_q.size() < 2);
      check({tag, ".count"}, count, model_q.size());
      if (model_q.size() > 0) check({tag, ".out_data"}, out_data, model_q[0]);
   endtask

   // Continuous property checks, sampled on the falling edge.
   logic             prev_hold = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold <= 1'b0;
      end else begin
         if (prev_hold) check("stable_out_data", out_data, prev_data);
         check("in_ready_vs_count", in_ready, count < 2);
         check("count_max", count <= 2, 1);
         prev_hold <= out_valid && !out_ready;
         prev_data <= out_data;
      end
   end

   typedef struct {
      logic             iv;
      logic [WIDTH-1:0] d;
      logic             ordy;
      logic             e_ov;
      logic [WIDTH-1:0] e_od;
      logic             e_ir;
      logic [1:0]       e_cnt;
   } vec_t;

   vec_t vecs[12];

   initial begin
      bit               held;
      logic             iv;
      logic [WIDTH-1:0] d;

      // Expected outputs after each edge, starting from an empty buffer.
      vecs[0]  = '{1'b1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 2'd1};
      vecs[1]  = '{1'b1, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 2'd1};
      vecs[2]  = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 2'd1};
      vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1, 2'd0};
      vecs[4]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1};
      vecs[5]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 2'd2};
      vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 2'd2};
      vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1, 2'd1};
      vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 1'b1, 2'd0};
      vecs[9]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h33, 1'b1, 2'd1};
      vecs[10] = '{1'b1, 8'h44, 1'b1, 1'b1, 8'h44, 1'b1, 2'd1};
      vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 1'b1, 2'd0};

      // Reset held with traffic present on the input.
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hAA;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst.out_valid", out_valid, 0);
         check("rst.in_ready", in_ready, 1);
         check("rst.count", count, 0);
         check("rst.out_data", out_data, 0);
      end
      rst_n = 1'b1;
      model_q.delete();

      // Directed vector table.
      for (int i = 0; i < 12; i++) begin
         cycle(vecs[i].iv, vecs[i].d, vecs[i].ordy);
         check($sformatf("vec%0d.out_valid", i), out_valid, vecs[i].e_ov);
         check($sformatf("vec%0d.out_data", i), out_data, vecs[i].e_od);
         check($sformatf("vec%0d.in_ready", i), in_ready, vecs[i].e_ir);
         check($sformatf("vec%0d.count", i), count, vecs[i].e_cnt);
      end

      // Streaming at full rate: each word visible one cycle after acceptance.
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 8'(i), 1'b1);
         check("stream.out_data", out_data, i);
         check("stream.count", count, 1);
         check("stream.in_ready", in_ready, 1);
      end
      cycle(1'b0, 8'h00, 1'b1);
      check_model("stream_end");

      // Fill to FULL, then asynchronous reset in the middle of a cycle.
      cycle(1'b1, 8'h55, 1'b0);
      cycle(1'b1, 8'h66, 1'b0);
      check("full.count", count, 2);
      check("full.in_ready", in_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst.out_valid", out_valid, 0);
      check("async_rst.in_ready", in_ready, 1);
      check("async_rst.count", count, 0);
      check("async_rst.out_data", out_data, 0);
      #3;
      rst_n = 1'b1;
      model_q.delete();
      cycle(1'b1, 8'h77, 1'b0);
      check("post_rst.out_data", out_data, 8'h77);
      check("post_rst.count", count, 1);

      // Randomized traffic against the queue model. in_data is held while a
      // word waits on a low in_ready, as the upstream contract requires.
      held = 1'b0;
      d    = '0;
      for (int i = 0; i < 10000; i++) begin
         if (held) begin
            iv = 1'b1;
         end else begin
            iv = ($urandom_range(0, 3) != 0);
            d  = 8'($urandom);
         end
         held = iv && !in_ready;
         cycle(iv, d, ($urandom_range(0, 2) != 0));
         check_model("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

endmodule
